multiplexer_8to1_tdm: RTL

Registered 8-to-1 time-division multiplexer that collects 8 input lanes onto one output lane. It is the collecting end of the 1-to-8 demultiplexer path. A 3-bit lane pointer scans the lanes round-robin and skips lanes that are masked off. Each selected lane is issued as one beat, together with its lane index, on a valid/ready output handshake. Sits upstream of the 1-to-8 demultiplexer, which uses out_select as its select input.

---
 rtl/multiplexer_8to1_tdm_if.sv | 37 +++
 rtl/multiplexer_8to1_tdm.sv | 104 ++++++++++
 2 files changed

// File: rtl/multiplexer_8to1_tdm_if.sv
// Bundle for the 8-to-1 TDM collector: lane inputs, scan controls and the valid/ready output beat.
// out_parity exists only when MULTIPLEXER_8TO1_TDM_PARITY_EN is defined.
interface multiplexer_8to1_tdm_if #(
    parameter int WIDTH = 1
);
    logic                 enable;
    logic [7:0]           lane_mask;
    logic [8*WIDTH-1:0]   in_data;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [2:0]           out_select;
    logic                 out_valid;
    logic                 frame_start;
`ifdef MULTIPLEXER_8TO1_TDM_PARITY_EN
    logic                 out_parity;

    modport master (
        input  enable, lane_mask, in_data, out_ready,
        output out_data, out_select, out_valid, frame_start, out_parity
    );

    modport slave (
        output enable, lane_mask, in_data, out_ready,
        input  out_data, out_select, out_valid, frame_start, out_parity
    );
`else
    modport master (
        input  enable, lane_mask, in_data, out_ready,
        output out_data, out_select, out_valid, frame_start
    );

    modport slave (
        output enable, lane_mask, in_data, out_ready,
        input  out_data, out_select, out_valid, frame_start
    );
`endif
endinterface

// File: rtl/multiplexer_8to1_tdm.sv
// Registered 8-to-1 time-division multiplexer: round-robin scan of unmasked lanes onto one valid/ready lane.
// Optional out_parity output enabled by defining MULTIPLEXER_8TO1_TDM_PARITY_EN.
module multiplexer_8to1_tdm #(
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    multiplexer_8to1_tdm_if.master   bus
);
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [2:0]       out_select_q, out_select_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_start_q, frame_start_d;
    logic [2:0]       ptr_q, ptr_d;
    logic             first_q, first_d;
`ifdef MULTIPLEXER_8TO1_TDM_PARITY_EN
    logic             out_parity_q, out_parity_d;
`endif

    logic [WIDTH-1:0] lane_data [8];
    logic [7:0]       hit;
    logic [2:0]       found_lane;
    logic             issue;

    // hit[k] is the mask bit of the lane k steps after the pointer
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
            assign hit[gi]       = bus.lane_mask[ptr_q + 3'(gi)];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest unmasked lane wins
    always_comb begin
        found_lane = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            if (hit[k]) begin
                found_lane = ptr_q + 3'(k);
            end
        end
    end

    assign issue = bus.enable && (bus.lane_mask != 8'd0) && (!out_valid_q || bus.out_ready);

    always_comb begin
        out_data_d    = out_data_q;
        out_select_d  = out_select_q;
        out_valid_d   = out_valid_q;
        frame_start_d = frame_start_q;
        ptr_d         = ptr_q;
        first_d       = first_q;
`ifdef MULTIPLEXER_8TO1_TDM_PARITY_EN
        out_parity_d  = out_parity_q;
`endif
        if (issue) begin
            out_data_d    = lane_data[found_lane];
            out_select_d  = found_lane;
            out_valid_d   = 1'b1;
            // out_select_q still holds the previously issued lane; a wrap or repeat opens a new frame
            frame_start_d = first_q || (found_lane <= out_select_q);
            ptr_d         = found_lane + 3'd1;
            first_d       = 1'b0;
`ifdef MULTIPLEXER_8TO1_TDM_PARITY_EN
            out_parity_d  = ^lane_data[found_lane];
`endif
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d   = 1'b0;
            frame_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q    <= '0;
            out_select_q  <= 3'd0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            ptr_q         <= 3'd0;
            first_q       <= 1'b1;
`ifdef MULTIPLEXER_8TO1_TDM_PARITY_EN
            out_parity_q  <= 1'b0;
`endif
        end else begin
            out_data_q    <= out_data_d;
            out_select_q  <= out_select_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
            ptr_q         <= ptr_d;
            first_q       <= first_d;
`ifdef MULTIPLEXER_8TO1_TDM_PARITY_EN
            out_parity_q  <= out_parity_d;
`endif
        end
    end

    assign bus.out_data    = out_data_q;
    assign bus.out_select  = out_select_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.frame_start = frame_start_q;
`ifdef MULTIPLEXER_8TO1_TDM_PARITY_EN
    assign bus.out_parity  = out_parity_q;
`endif

endmodule
